regfile_2r1w_clr: RTL
=====================

// Module: regfile_2r1w_clr
// PURPOSE
//  Parametrised register file for the processing-unit datapath: 2 async read ports (A, B), 1 sync write port (D).
//  Next generation of the 4x4 CPU register bank. Adds async reset, optional hard-wired zero R0,
//  write-to-read bypass, per-register dirty flags and a sequenced bulk-clear engine with busy handshake.
//  Sits between the instruction decoder (addresses) and the ALU (operands / result).
// PARAMETERS
//  N        2  address width; depth = 2**N registers
//  M        4  data width in bits
//  ZERO_R0  0  1: R0 always reads 0, writes to address 0 are discarded (still acked)
//  BYPASS   1  1: same-cycle accepted write is forwarded to matching read port
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       async active-low reset
//  write    in   1       write request for d_adr/d_dat
//  wr_ack   out  1       comb: write & ~busy; write commits at this edge only when 1
//  a_adr    in   N       read port A address
//  b_adr    in   N       read port B address
//  d_adr    in   N       write address
//  d_dat    in   M       write data
//  a_dat    out  M       read data A (combinational)
//  b_dat    out  M       read data B (combinational)
//  clr_req  in   1       bulk-clear request, sampled at posedge
//  busy     out  1       registered; 1 while clear sweep in progress
//  dirty    out  2**N    registered; bit i = reg i written since last reset/clear
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, dirty 0, busy 0, FSM IDLE, clr_ptr 0. Reads give 0 during reset.
//  - Write: at posedge with wr_ack=1: mem[d_adr]<=d_dat and dirty[d_adr]<=1. Latency 1 cycle to storage.
//  - Read: x_dat = mem[x_adr]. If BYPASS && wr_ack && x_adr==d_adr, x_dat = d_dat (0-cycle forward).
//  - ZERO_R0=1 overrides everything for address 0: read 0, no bypass, dirty[0] stays 0.
//  - FSM states IDLE, CLEAR (2-state).
//    IDLE  --clr_req--> CLEAR, clr_ptr<=0, busy<=1 (busy visible the cycle after clr_req is sampled).
//    CLEAR: each cycle mem[clr_ptr]<=0, dirty[clr_ptr]<=0, clr_ptr++.
//    Leaves to IDLE at the edge that clears address 2**N-1; busy<=0 at that same edge.
//    Sweep occupies exactly 2**N cycles with busy=1.
//  - clr_req while busy: ignored. No queuing.
//  - write while busy: wr_ack=0, write dropped, no state change, no bypass. Requester must hold or retry.
//  - write and clr_req in same IDLE cycle: write commits, clear starts next cycle, and the sweep later zeroes it.
//  - Reads during CLEAR return current storage: already-swept entries read 0, others read old values.
//  - clr_ptr is N bits and wraps naturally; the terminal condition is clr_ptr == 2**N-1.
//  - Reset asserted mid-sweep aborts it: IDLE, busy 0, full zero state.
//  - All addresses in range by construction (N-bit). No error outputs.
// STRUCTURE
//  - Package regfile_pkg: typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e.
//  - Sub-module regfile_clr_fsm: state, clr_ptr and busy. Outputs clr_we and clr_adr to the storage array.
//  - Storage, dirty vector, bypass muxes and wr_ack stay in the top module.
//  - Storage is a flop array with async reset. No RAM macro inference required.
// TESTING (defaults N=2, M=4, BYPASS=1, ZERO_R0=0 unless stated)
//  1. Reset -> a_adr=0..3 read 0, busy=0, dirty=4'b0000.
//  2. Write R2=4'hA, then read A=2, B=2 -> both 4'hA next cycle. Same-cycle read of addr 2 already shows 4'hA (bypass). dirty=4'b0100.
//  3. Load R0..R3=1,2,3,4, then pulse clr_req -> busy=1 for exactly 4 cycles.
//     Mid-sweep: R0 reads 0 while R3 still reads 4. Afterwards all read 0 and dirty=0.
//  4. write=1 with d_adr=1, d_dat=5 while busy -> wr_ack=0. R1 unchanged after sweep, no bypass on a_adr=1.
//  5. ZERO_R0=1: write R0=4'hF -> wr_ack=1, a_dat(0)=0, dirty[0]=0. Write to R1 behaves normally.
//  6. rst_n low for 1 cycle during 2nd sweep cycle -> busy drops asynchronously. All regs 0.
//     The next clr_req runs a full 4-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the 2-read/1-write register file and its bulk-clear sequencer.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: sweeps every register address once, one per cycle, while busy.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr_req,
  output logic         o_busy,
  output logic         o_clr_we,
  output logic [N-1:0] o_clr_adr
);

  rf_state_e      r_state;
  logic [N-1:0]   r_clr_ptr;
  logic           r_busy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RF_IDLE;
      r_clr_ptr <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        RF_IDLE: begin
          if (i_clr_req) begin
            r_state   <= RF_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
          end
        end
        RF_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + N'(1);
          // The edge that clears the last address also ends the sweep.
          if (r_clr_ptr == '1) begin
            r_state <= RF_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= RF_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_clr_we  = (r_state == RF_CLEAR);
  assign o_clr_adr = r_clr_ptr;

endmodule

// File: rtl/regfile_2r1w_clr.sv
// Register file with two combinational read ports, one synchronous write port,
// optional hard-wired zero R0, write-to-read bypass, dirty flags and a sequenced bulk clear.
module regfile_2r1w_clr
  import regfile_pkg::*;
#(
  parameter int N       = 2,
  parameter int M       = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  output logic              wr_ack,
  input  logic [N-1:0]      a_adr,
  input  logic [N-1:0]      b_adr,
  input  logic [N-1:0]      d_adr,
  input  logic [M-1:0]      d_dat,
  output logic [M-1:0]      a_dat,
  output logic [M-1:0]      b_dat,
  input  logic              clr_req,
  output logic              busy,
  output logic [(2**N)-1:0] dirty
);

  localparam int D = 2**N;

  logic [M-1:0] r_mem [D];
  logic [D-1:0] r_dirty;

  logic         w_clr_we;
  logic [N-1:0] w_clr_adr;
  logic         w_wr_en;
  logic         w_fwd;

  regfile_clr_fsm #(.N(N)) u_clr_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr_req (clr_req),
    .o_busy    (busy),
    .o_clr_we  (w_clr_we),
    .o_clr_adr (w_clr_adr)
  );

  assign wr_ack  = write & ~busy;
  // Writes to R0 are acknowledged but never stored when R0 is hard-wired to zero.
  assign w_wr_en = wr_ack && !((ZERO_R0 != 0) && (d_adr == '0));
  // Forwarding is suppressed in reset so reads report the cleared array.
  assign w_fwd   = (BYPASS != 0) && wr_ack && rst_n;

  // NOTE: the storage is a flop array, so it is reset explicitly; a RAM macro would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
      r_dirty <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_adr]   <= '0;
      r_dirty[w_clr_adr] <= 1'b0;
    end else if (w_wr_en) begin
      r_mem[d_adr]   <= d_dat;
      r_dirty[d_adr] <= 1'b1;
    end
  end

  assign dirty = r_dirty;

  // NOTE: outputs get an unconditional default first so no path leaves them unassigned (no latch).
  always_comb begin
    a_dat = r_mem[a_adr];
    if (w_fwd && (a_adr == d_adr)) a_dat = d_dat;
    if ((ZERO_R0 != 0) && (a_adr == '0)) a_dat = '0;

    b_dat = r_mem[b_adr];
    if (w_fwd && (b_adr == d_adr)) b_dat = d_dat;
    if ((ZERO_R0 != 0) && (b_adr == '0)) b_dat = '0;
  end

endmodule
